// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - byte-stream instruction memory loader
// Assembles framed big-endian words into imem and holds the CPU in reset until done.
module imem_stream_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERR} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic        accept;
  logic [15:0] hdr_count;
  logic        word_end;
  logic        word_last;

  assign accept    = in_valid && in_ready;
  assign hdr_count = {count[15:8], in_data};
  assign word_end  = (byte_idx == 2'd3);
  assign word_last = word_end && (word_idx == count - 16'd1);

  always_comb begin
    state_next = state;
    case (state)
      HDR_HI: if (accept) state_next = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_count == 16'd0)            state_next = DONE;
          else if (32'(hdr_count) > DEPTH)  state_next = ERR;
          else                               state_next = DATA;
        end
      end
      DATA:    if (accept && word_last) state_next = DONE;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HDR_HI;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_rst    <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state     <= state_next;
      // Registered ready follows the next state so it drops with the final write
      in_ready  <= (state_next == HDR_HI) || (state_next == HDR_LO) || (state_next == DATA);
      imem_we   <= 1'b0;
      load_done <= (state == DONE);
      cpu_rst   <= (state == DONE);
      load_err  <= (state == ERR);
      if (accept) begin
        case (state)
          HDR_HI: count[15:8] <= in_data;
          HDR_LO: count[7:0]  <= in_data;
          DATA: begin
            shift    <= {shift[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (word_end) begin
              imem_we    <= 1'b1;
              imem_addr  <= BASE_ADDR + {14'b0, word_idx, 2'b00};
              imem_wdata <= {shift, in_data};
              word_idx   <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - scoreboard bench for imem_stream_loader
module tb_imem_stream_loader;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          we_count = 0;
  logic [31:0] last_addr = 32'h0;

  imem_stream_loader #(.BASE_ADDR(BASE), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the next queued expectation
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_count++;
      last_addr = imem_addr;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h want none", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e.addr);
        check("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    tick(3);
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    tick(gap);
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 want byte 0x%02h accepted", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] bytes[$], input int maxgap);
    foreach (bytes[i]) send_byte(bytes[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_imem_we"}, {31'b0, imem_we}, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, BASE);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_rst"}, {31'b0, cpu_rst}, 32'd0);
    check({tag, "_load_done"}, {31'b0, load_done}, 32'd0);
    check({tag, "_load_err"}, {31'b0, load_err}, 32'd0);
  endtask

  task automatic two_word(input int maxgap, input string tag);
    logic [7:0] img[$];
    img = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
    do_reset();
    push_exp(32'h0000_3000, 32'h2401_0005);
    push_exp(32'h0000_3004, 32'hAC01_0000);
    send_image(img, maxgap);
    check({tag, "_ready_drop"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_done_early"}, {31'b0, load_done}, 32'd0);
    tick(1);
    check({tag, "_load_done"}, {31'b0, load_done}, 32'd1);
    check({tag, "_cpu_rst"}, {31'b0, cpu_rst}, 32'd1);
    tick(5);
    check({tag, "_ready_held"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_done_held"}, {31'b0, load_done}, 32'd1);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] img[$];
    int base_we;

    tick(2);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(1);
    check("ready_after_reset", {31'b0, in_ready}, 32'd1);

    two_word(0, "nogap");
    two_word(5, "gaps");

    // Zero-length image
    do_reset();
    base_we = we_count;
    img = '{8'h00, 8'h00};
    send_image(img, 0);
    tick(2);
    check("zero_load_done", {31'b0, load_done}, 32'd1);
    check("zero_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("zero_no_we", we_count - base_we, 32'd0);

    // Oversize image, then offered bytes must be ignored
    do_reset();
    base_we = we_count;
    img = '{8'h04, 8'h01};
    send_image(img, 0);
    tick(2);
    check("err_load_err", {31'b0, load_err}, 32'd1);
    check("err_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check("err_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'(i * 17);
      tick(1);
    end
    in_valid = 1'b0;
    check("err_no_we", we_count - base_we, 32'd0);
    check("err_held", {31'b0, load_err}, 32'd1);
    check("err_no_done", {31'b0, load_done}, 32'd0);

    // Reset mid-load after the 9th data byte of a 5-word image
    do_reset();
    push_exp(32'h0000_3000, 32'h0102_0304);
    push_exp(32'h0000_3004, 32'h0506_0708);
    img = '{8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_image(img, 0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_pending", exp_q.size(), 32'd0);
    tick(2);
    rst = 1'b1;
    push_exp(32'h0000_3000, 32'h1234_5678);
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send_image(img, 0);
    tick(1);
    check("reload_done", {31'b0, load_done}, 32'd1);
    check("reload_pending", exp_q.size(), 32'd0);

    // Maximum image: 1024 incrementing words
    do_reset();
    base_we = we_count;
    img = '{8'h04, 8'h00};
    for (int w = 0; w < 1024; w++) begin
      push_exp(BASE + 32'(w) * 32'd4, 32'(w));
      img.push_back(8'h00);
      img.push_back(8'h00);
      img.push_back(8'(w >> 8));
      img.push_back(8'(w));
    end
    send_image(img, 0);
    tick(1);
    check("max_we_count", we_count - base_we, 32'd1024);
    check("max_last_addr", last_addr, 32'h0000_3FFC);
    check("max_load_done", {31'b0, load_done}, 32'd1);
    check("max_pending", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
